// File: rtl/onehot_replay_decoder.sv
// onehot_replay_decoder: buffers 3-bit codes (or "none" markers) in a FIFO
// and replays each as a registered one-hot strobe held HOLD cycles, GAP idle.
module onehot_replay_decoder #(
    parameter int CODE_W = 3,
    parameter int DEPTH  = 4,
    parameter int HOLD   = 2,
    parameter int GAP    = 1,
    localparam int OUT_W = 2 ** CODE_W,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [CODE_W-1:0] in_code,
    input  logic              in_none,
    output logic              in_ready,
    output logic [OUT_W-1:0]  out_onehot,
    output logic [CODE_W-1:0] out_code,
    output logic              out_active,
    output logic              out_none,
    output logic [CNT_W-1:0]  fifo_count,
    output logic              overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int TMAX  = (HOLD > GAP) ? HOLD : GAP;
    localparam int TMR_W = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TMR_W-1:0] HOLD_M1 = TMR_W'(HOLD - 1);
    localparam logic [TMR_W-1:0] GAP_M1  = (GAP > 0) ? TMR_W'(GAP - 1) : '0;
    localparam bit               GAP_EN  = (GAP > 0);
    localparam logic [CNT_W-1:0] FULL_N  = CNT_W'(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic [CODE_W:0]     mem_q [DEPTH];
    logic [PTR_W-1:0]    wr_q, rd_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          state_q, state_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic                ovf_q;
    logic [OUT_W-1:0]    onehot_q;
    logic [CODE_W-1:0]   code_q;
    logic                active_q, none_q;

    logic full, empty, push, pop, load, clear;
    logic [CODE_W:0]   head;
    logic              head_none;
    logic [CODE_W-1:0] head_code;

    assign full      = (cnt_q == FULL_N);
    assign empty     = (cnt_q == '0);
    assign push      = in_valid && !full;
    assign head      = mem_q[rd_q];
    assign head_none = head[CODE_W];
    assign head_code = head[CODE_W-1:0];

    assign in_ready   = !full;
    assign fifo_count = cnt_q;
    assign overflow   = ovf_q;
    assign out_onehot = onehot_q;
    assign out_code   = code_q;
    assign out_active = active_q;
    assign out_none   = none_q;

    // Next-state logic: pop a new entry whenever a hold/gap slot expires.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        pop     = 1'b0;
        load    = 1'b0;
        clear   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    load    = 1'b1;
                    tmr_d   = HOLD_M1;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - 1'b1;
                end else if (GAP_EN) begin
                    tmr_d   = GAP_M1;
                    clear   = 1'b1;
                    state_d = ST_GAP;
                end else if (!empty) begin
                    pop   = 1'b1;
                    load  = 1'b1;
                    tmr_d = HOLD_M1;
                end else begin
                    clear   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - 1'b1;
                end else if (!empty) begin
                    pop     = 1'b1;
                    load    = 1'b1;
                    tmr_d   = HOLD_M1;
                    state_d = ST_DRIVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                clear   = 1'b1;
                tmr_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Occupancy tracks push/pop; simultaneous push and pop leave it unchanged.
    always_comb begin
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO storage is not reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= {in_none, in_code};
        end
    end

    // Pointers, count, FSM, timer and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            state_q <= ST_IDLE;
            tmr_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            tmr_q   <= tmr_d;
            if (in_valid && full) ovf_q <= 1'b1;
        end
    end

    // Registered strobe outputs; a none-entry drives active with zero strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            onehot_q <= '0;
            code_q   <= '0;
            active_q <= 1'b0;
            none_q   <= 1'b0;
        end else if (load) begin
            onehot_q <= head_none ? '0 : (OUT_W'(1) << head_code);
            code_q   <= head_none ? '0 : head_code;
            active_q <= 1'b1;
            none_q   <= head_none;
        end else if (clear) begin
            onehot_q <= '0;
            code_q   <= '0;
            active_q <= 1'b0;
            none_q   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_onehot_replay_decoder.sv
// Bench for onehot_replay_decoder: two instances (GAP=1, GAP=0) checked
// every cycle against a slot-based queue model plus literal spot checks.
module tb_onehot_replay_decoder;

    localparam int DEPTH = 4;
    localparam int HOLD  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [2:0] in_code = '0;
    logic       in_none = 1'b0;

    logic       a_ready, a_active, a_none, a_ovf;
    logic [7:0] a_onehot;
    logic [2:0] a_code, a_cnt;
    logic       b_ready, b_active, b_none, b_ovf;
    logic [7:0] b_onehot;
    logic [2:0] b_code, b_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    bit started = 0;

    logic [3:0] mq [2][$];
    int         rem [2];
    logic [3:0] cur [2];
    bit         movf [2];

    always #5 clk = ~clk;

    onehot_replay_decoder #(.CODE_W(3), .DEPTH(DEPTH), .HOLD(HOLD), .GAP(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_code(in_code),
        .in_none(in_none), .in_ready(a_ready), .out_onehot(a_onehot),
        .out_code(a_code), .out_active(a_active), .out_none(a_none),
        .fifo_count(a_cnt), .overflow(a_ovf)
    );

    onehot_replay_decoder #(.CODE_W(3), .DEPTH(DEPTH), .HOLD(HOLD), .GAP(0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_code(in_code),
        .in_none(in_none), .in_ready(b_ready), .out_onehot(b_onehot),
        .out_code(b_code), .out_active(b_active), .out_none(b_none),
        .fifo_count(b_cnt), .overflow(b_ovf)
    );

    function automatic int gap_of(input int m);
        return (m == 0) ? 1 : 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Each entry owns a slot of HOLD+GAP cycles; the first HOLD drive it.
    task automatic model_edge();
        for (int m = 0; m < 2; m++) begin
            int sz;
            sz = mq[m].size();
            if (rst) begin
                mq[m].delete();
                rem[m]  = 0;
                cur[m]  = '0;
                movf[m] = 0;
            end else begin
                if (in_valid && sz >= DEPTH) movf[m] = 1;
                if (rem[m] > 1) begin
                    rem[m]--;
                end else if (sz > 0) begin
                    cur[m] = mq[m].pop_front();
                    rem[m] = HOLD + gap_of(m);
                end else begin
                    rem[m] = 0;
                end
                if (in_valid && sz < DEPTH) mq[m].push_back({in_none, in_code});
            end
        end
    endtask

    function automatic bit e_active(input int m);
        return rem[m] > gap_of(m);
    endfunction

    function automatic bit e_none(input int m);
        return e_active(m) && cur[m][3];
    endfunction

    function automatic logic [2:0] e_code(input int m);
        return (e_active(m) && !cur[m][3]) ? cur[m][2:0] : 3'd0;
    endfunction

    function automatic logic [7:0] e_onehot(input int m);
        logic [7:0] v;
        v = '0;
        if (e_active(m) && !cur[m][3]) v[cur[m][2:0]] = 1'b1;
        return v;
    endfunction

    // Single compare process: all outputs of both instances every cycle.
    always @(negedge clk) begin
        if (started) begin
            chk("a_onehot", a_onehot, e_onehot(0));
            chk("a_code",   a_code,   e_code(0));
            chk("a_active", a_active, e_active(0));
            chk("a_none",   a_none,   e_none(0));
            chk("a_count",  a_cnt,    mq[0].size());
            chk("a_ready",  a_ready,  mq[0].size() < DEPTH);
            chk("a_ovf",    a_ovf,    movf[0]);
            chk("b_onehot", b_onehot, e_onehot(1));
            chk("b_code",   b_code,   e_code(1));
            chk("b_active", b_active, e_active(1));
            chk("b_none",   b_none,   e_none(1));
            chk("b_count",  b_cnt,    mq[1].size());
            chk("b_ready",  b_ready,  mq[1].size() < DEPTH);
            chk("b_ovf",    b_ovf,    movf[1]);
            chk("a_cnt_le_depth", a_cnt <= 3'(DEPTH), 1);
        end
    end

    task automatic step(input bit r, input bit v, input logic [2:0] c, input bit n);
        rst = r;
        in_valid = v;
        in_code = c;
        in_none = n;
        @(posedge clk);
        model_edge();
        started = 1;
        #1;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(0, 0, 3'd0, 0);
    endtask

    initial begin
        step(1, 0, 3'd0, 0);
        step(1, 0, 3'd0, 0);
        chk("rst_onehot", a_onehot, 8'h00);
        chk("rst_ready",  a_ready,  1);
        chk("rst_count",  a_cnt,    0);
        chk("rst_ovf",    a_ovf,    0);

        // Reset held 3 cycles mid-DRIVE with entries still buffered.
        step(0, 1, 3'd2, 0);
        step(0, 1, 3'd4, 0);
        step(0, 1, 3'd6, 0);
        chk("t1_mid_drive", a_onehot, 8'h04);
        step(1, 1, 3'd1, 0);
        step(1, 0, 3'd0, 0);
        step(1, 0, 3'd0, 0);
        step(0, 0, 3'd0, 0);
        chk("t1_onehot", a_onehot, 8'h00);
        chk("t1_count",  a_cnt,    0);
        chk("t1_ready",  a_ready,  1);
        chk("t1_ovf",    a_ovf,    0);

        // Single code 5: one cycle in FIFO, 2 strobe cycles, 1 gap cycle.
        step(0, 1, 3'd5, 0);
        chk("t2_latency", a_onehot, 8'h00);
        step(0, 0, 3'd0, 0);
        chk("t2_hold0", a_onehot, 8'h20);
        step(0, 0, 3'd0, 0);
        chk("t2_hold1", a_onehot, 8'h20);
        step(0, 0, 3'd0, 0);
        chk("t2_gap", a_onehot, 8'h00);
        step(0, 0, 3'd0, 0);
        chk("t2_idle", a_active, 0);
        idle(3);

        // Back-to-back 0..7 overruns the FIFO.
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 3'(i), 0);
            if (i == 1) chk("t3_first", a_onehot, 8'h01);
        end
        chk("t3_ovf", a_ovf, 1);
        idle(30);
        chk("t3_drained", a_active, 0);

        // None-entry: active with no strobe.
        step(1, 0, 3'd0, 0);
        step(0, 1, 3'd3, 1);
        step(0, 0, 3'd0, 0);
        chk("t4_active", a_active, 1);
        chk("t4_none",   a_none,   1);
        chk("t4_onehot", a_onehot, 8'h00);
        idle(6);

        // GAP=0 instance: 3 then 6 with no zero cycle between.
        step(0, 1, 3'd3, 0);
        step(0, 1, 3'd6, 0);
        chk("t5_s0", b_onehot, 8'h08);
        step(0, 0, 3'd0, 0);
        chk("t5_s1", b_onehot, 8'h08);
        step(0, 0, 3'd0, 0);
        chk("t5_s2", b_onehot, 8'h40);
        step(0, 0, 3'd0, 0);
        chk("t5_s3", b_onehot, 8'h40);
        step(0, 0, 3'd0, 0);
        chk("t5_end", b_onehot, 8'h00);
        idle(4);

        // Random stream with occasional resets and bursts.
        for (int i = 0; i < 3000; i++) begin
            bit r, v, n;
            int pct;
            pct = ((i / 200) % 2 == 0) ? 35 : 80;
            r = ($urandom_range(0, 299) == 0);
            v = ($urandom_range(0, 99) < pct);
            n = ($urandom_range(0, 7) == 0);
            step(r, v, 3'($urandom_range(0, 7)), n);
        end
        idle(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
